vdf_sq_sequencer: RTL and testbench
===================================

# vdf_sq_sequencer

Sequences a VDF evaluation over the pipelined polynomial modular squarer. It accepts a start value and an iteration count T. It feeds each squarer output back as the next input T times, then issues one final reduce-only pass to normalise the redundant coefficients, and presents the result. It sits between the host/AXI command logic and the squarer wrapper, and owns the squarer's i_val, i_reduce_only and i_dat inputs exclusively.

## Interface
- WORD_BITS, 35, bits per polynomial word
- NUM_WORDS, 30, words in the modulus
- REDUN_WORD_BITS, 1, redundant bits per coefficient
- I_WORD, NUM_WORDS+1, coefficients per operand
- COEF_BITS, WORD_BITS+REDUN_WORD_BITS, coefficient width
- T_BITS, 64, iteration-count width
- WDOG_CYCLES, 1024, maximum cycles allowed between issue and squarer return

Ports:
- i_clk  in  1  clock; the block uses one clock
- i_rst  in  1  reset; synchronous and active-high
- i_val  in  1  start request
- o_rdy  out  1  start accept; high only in IDLE
- i_dat  in  I_WORD*COEF_BITS  start value x
- i_t  in  T_BITS  number of squarings
- i_abort  in  1  cancel the current job
- o_sq_val  out  1  issue to squarer, single-cycle pulse
- o_sq_reduce_only  out  1  marks the issue as a reduce-only pass
- o_sq_dat  out  I_WORD*COEF_BITS  squarer operand
- i_sq_val  in  1  squarer result valid
- i_sq_dat  in  I_WORD*COEF_BITS  squarer result
- o_val  out  1  result valid; held until accepted
- i_rdy  in  1  result accept
- o_dat  out  I_WORD*COEF_BITS  x^(2^T), fully reduced
- o_iter  out  T_BITS  squarings completed in the current job
- o_err  out  1  watchdog fired; sticky

## Operation
FSM states: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE: o_rdy=1. On i_val&o_rdy: capture i_dat into the operand register, load remaining=i_t, clear o_iter and o_err, go to ISSUE.
- ISSUE (one cycle): assert o_sq_val with the operand register on o_sq_dat.
  - o_sq_reduce_only = (remaining==0).
  - Clear the watchdog, go to WAIT.
- WAIT, i_sq_val high, non-reduce issue: capture i_sq_dat into the operand register, remaining-1, o_iter+1, go to ISSUE.
- WAIT, i_sq_val high, reduce-only issue: capture i_sq_dat into o_dat, go to DONE.
- DONE: o_val=1; o_dat and o_iter stable. On i_rdy, go to IDLE.
- T==0: the first issue is reduce-only. The result is x normalised.
- i_abort in ISSUE or DONE: go to IDLE next cycle. No squarer operation is outstanding in either state.
- i_abort in WAIT: go to DRAIN. Stay there until i_sq_val or watchdog expiry, discard the data, then go to IDLE.
- i_abort has priority over a same-cycle i_sq_val in WAIT. The FSM goes to IDLE directly because that result is the drained one.
- Watchdog: counts cycles in WAIT/DRAIN.
  - On reaching WDOG_CYCLES: set o_err, go to IDLE, drop the job.
  - o_err is cleared only by i_rst or the next accepted start.
- i_sq_val outside WAIT/DRAIN is ignored.
- remaining and o_iter wrap modulo 2^T_BITS; no saturation.

## Timing
- Reset values: state=IDLE, o_rdy=1, o_sq_val=0, o_sq_reduce_only=0, o_val=0, o_err=0, o_iter=0, o_dat=0, o_sq_dat=0.
- Start accept cycle N: first o_sq_val at cycle N+1.
- Squarer return at cycle M: next o_sq_val at M+1.
  - Loop period = squarer latency L + 1 cycles.
  - At most one squarer operation is outstanding.
- Total latency from accept to o_val = (T+1)*(L+1) + 1 cycles.
- i_rst mid-job returns to IDLE next cycle. Squarer results arriving after reset are ignored by the IDLE rule above.
- o_val/i_rdy follows valid/ready rules: o_dat holds while o_val&!i_rdy.

## Structure
- Package vdf_sq_seq_pkg holds:
  - state enum: IDLE, ISSUE, WAIT, DONE, DRAIN
  - operand typedef: logic [I_WORD-1:0][COEF_BITS-1:0]
- One sub-module, vdf_sq_watchdog: a counter with clear, enable and expiry pulse, parameterised by WDOG_CYCLES.
- The squarer wrapper is instantiated in the top-level, not inside this block.

## Test plan
- T=3, x=5, squarer model with L=6 → exactly 4 o_sq_val pulses; only the 4th has reduce_only=1. o_dat=5^8 mod N, o_iter=3, o_val after 29 cycles.
- T=0, x=N+2 (unreduced) → a single reduce-only issue; o_dat=2, o_iter=0.
- T=10, i_rdy held low 20 cycles in DONE → o_val and o_dat stable, o_rdy=0. i_rdy then pulses → IDLE, o_rdy=1 next cycle.
- i_abort in WAIT at iteration 4 → DRAIN, no new o_sq_val, late i_sq_val discarded, IDLE. A following start with T=1 gives the correct result.
- Squarer model never returns, WDOG_CYCLES=16 → o_err=1 after 16 WAIT cycles, IDLE. o_err clears on the next accepted start.
- i_rst asserted mid-loop, stale i_sq_val one cycle later → all outputs at reset values, no issue generated.

Source files
------------

// File: rtl/vdf_sq_seq_pkg.sv
// Shared types and sizing for the VDF squaring sequencer.
package vdf_sq_seq_pkg;

  localparam int WORD_BITS       = 35;
  localparam int NUM_WORDS       = 30;
  localparam int REDUN_WORD_BITS = 1;
  localparam int I_WORD          = NUM_WORDS + 1;
  localparam int COEF_BITS       = WORD_BITS + REDUN_WORD_BITS;
  localparam int T_BITS          = 64;
  localparam int OPER_BITS       = I_WORD * COEF_BITS;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    DRAIN
  } state_t;

  typedef logic [I_WORD-1:0][COEF_BITS-1:0] operand_t;

endpackage

// File: rtl/vdf_sq_sequencer_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and pulses
// o_expire on the WDOG_CYCLES-th enabled cycle.
module vdf_sq_watchdog #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_BITS = $clog2(WDOG_CYCLES + 1);

  logic [CNT_BITS-1:0] r_cnt;
  logic                w_at_limit;

  assign w_at_limit = (r_cnt == CNT_BITS'(WDOG_CYCLES - 1));
  assign o_expire   = i_en && w_at_limit;

  // Count enabled cycles; park at the limit so the counter never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_limit) begin
      r_cnt <= r_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/vdf_sq_sequencer.sv
// VDF sequencer: loops the squarer result back T times, then issues one
// reduce-only pass and presents the normalised result.
module vdf_sq_sequencer
  import vdf_sq_seq_pkg::*;
#(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_val,
  output logic                 o_rdy,
  input  logic [OPER_BITS-1:0] i_dat,
  input  logic [T_BITS-1:0]    i_t,
  input  logic                 i_abort,
  output logic                 o_sq_val,
  output logic                 o_sq_reduce_only,
  output logic [OPER_BITS-1:0] o_sq_dat,
  input  logic                 i_sq_val,
  input  logic [OPER_BITS-1:0] i_sq_dat,
  output logic                 o_val,
  input  logic                 i_rdy,
  output logic [OPER_BITS-1:0] o_dat,
  output logic [T_BITS-1:0]    o_iter,
  output logic                 o_err
);

  state_t             r_state;
  state_t             w_next;
  operand_t           r_operand;
  operand_t           r_dat;
  logic [T_BITS-1:0]  r_remaining;
  logic [T_BITS-1:0]  r_iter;
  logic               r_err;

  logic w_last;
  logic w_in_flight;
  logic w_expire;
  logic w_accept;
  logic w_take_step;
  logic w_take_final;
  logic w_wd_fire;

  // remaining only changes on a squarer return, so it still marks the
  // outstanding pass as reduce-only while we sit in WAIT.
  assign w_last      = (r_remaining == '0);
  assign w_in_flight = (r_state == WAIT) || (r_state == DRAIN);

  assign w_accept     = (r_state == IDLE) && i_val;
  assign w_take_step  = (r_state == WAIT) && i_sq_val && !i_abort && !w_last;
  assign w_take_final = (r_state == WAIT) && i_sq_val && !i_abort && w_last;
  assign w_wd_fire    = w_in_flight && w_expire && !i_sq_val;

  vdf_sq_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (r_state == ISSUE),
    .i_en     (w_in_flight),
    .o_expire (w_expire)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; abort beats a same-cycle return, a return beats expiry.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (i_val) w_next = ISSUE;
      ISSUE: w_next = i_abort ? IDLE : WAIT;
      WAIT: begin
        if (i_sq_val && i_abort) w_next = IDLE;
        else if (i_sq_val)       w_next = w_last ? DONE : ISSUE;
        else if (w_expire)       w_next = IDLE;
        else if (i_abort)        w_next = DRAIN;
      end
      DONE:  if (i_abort || i_rdy) w_next = IDLE;
      DRAIN: if (i_sq_val || w_expire) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode from state and registered datapath.
  always_comb begin
    o_rdy            = (r_state == IDLE);
    o_sq_val         = (r_state == ISSUE) && !i_abort;
    o_sq_reduce_only = (r_state == ISSUE) && !i_abort && w_last;
    o_val            = (r_state == DONE);
    o_sq_dat         = r_operand;
    o_dat            = r_dat;
    o_iter           = r_iter;
    o_err            = r_err;
  end

  // Operand, iteration count, result and sticky error registers.
  always_ff @(posedge i_clk) begin
    // NOTE: the wide operand/result registers are reset as well, because
    // o_sq_dat and o_dat must read zero out of reset.
    if (i_rst) begin
      r_operand   <= '0;
      r_dat       <= '0;
      r_remaining <= '0;
      r_iter      <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_operand   <= i_dat;
        r_remaining <= i_t;
        r_iter      <= '0;
        r_err       <= 1'b0;
      end
      if (w_take_step) begin
        r_operand   <= i_sq_dat;
        r_remaining <= r_remaining - T_BITS'(1);
        r_iter      <= r_iter + T_BITS'(1);
      end
      if (w_take_final) begin
        r_dat <= i_sq_dat;
      end
      if (w_wd_fire) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vdf_sq_sequencer.sv
// Directed bench for vdf_sq_sequencer with a latency-6 squarer model and
// a scoreboard of expected results.
module tb_vdf_sq_sequencer;
  import vdf_sq_seq_pkg::*;

  localparam int L = 6;
  localparam int WDOG = 16;
  localparam longint unsigned N_MOD = 64'd1000003;

  logic                 clk = 1'b0;
  logic                 i_rst;
  logic                 i_val;
  logic                 o_rdy;
  logic [OPER_BITS-1:0] i_dat;
  logic [T_BITS-1:0]    i_t;
  logic                 i_abort;
  logic                 o_sq_val;
  logic                 o_sq_reduce_only;
  logic [OPER_BITS-1:0] o_sq_dat;
  logic                 i_sq_val;
  logic [OPER_BITS-1:0] i_sq_dat;
  logic                 o_val;
  logic                 i_rdy;
  logic [OPER_BITS-1:0] o_dat;
  logic [T_BITS-1:0]    o_iter;
  logic                 o_err;

  always #5 clk = ~clk;

  vdf_sq_sequencer #(.WDOG_CYCLES(WDOG)) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_val            (i_val),
    .o_rdy            (o_rdy),
    .i_dat            (i_dat),
    .i_t              (i_t),
    .i_abort          (i_abort),
    .o_sq_val         (o_sq_val),
    .o_sq_reduce_only (o_sq_reduce_only),
    .o_sq_dat         (o_sq_dat),
    .i_sq_val         (i_sq_val),
    .i_sq_dat         (i_sq_dat),
    .o_val            (o_val),
    .i_rdy            (i_rdy),
    .o_dat            (o_dat),
    .o_iter           (o_iter),
    .o_err            (o_err)
  );

  // ---------------- squarer model (integer stand-in, modulus N_MOD) ------
  // A normal pass returns the square in redundant form (+N), a reduce-only
  // pass returns the canonical residue.
  logic                 sq_en;
  logic                 inj_val;
  logic [OPER_BITS-1:0] inj_dat;
  logic [L-1:0]         pv = '0;
  logic [63:0]          pd [L];

  function automatic longint unsigned sq_model(input longint unsigned x, input logic red);
    if (red) return x % N_MOD;
    return ((x * x) % N_MOD) + N_MOD;
  endfunction

  always @(posedge clk) begin
    pv    <= {pv[L-2:0], o_sq_val & sq_en};
    pd[0] <= sq_model(o_sq_dat[63:0], o_sq_reduce_only);
    for (int k = L - 1; k > 0; k--) pd[k] <= pd[k-1];
  end

  assign i_sq_val = pv[L-1] | inj_val;
  assign i_sq_dat = inj_val ? inj_dat : OPER_BITS'(pd[L-1]);

  // ---------------- issue monitor ----------------
  int n_issue;
  int n_red;
  logic last_red;

  always @(posedge clk) begin
    if (o_sq_val === 1'b1) begin
      n_issue  = n_issue + 1;
      if (o_sq_reduce_only === 1'b1) n_red = n_red + 1;
      last_red = o_sq_reduce_only;
    end
  end

  // ---------------- scoreboard & checking ----------------
  typedef struct {
    logic [OPER_BITS-1:0] dat;
    longint unsigned      iter;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  function automatic longint unsigned exp_result(input longint unsigned x, input longint unsigned t);
    longint unsigned y;
    y = x % N_MOD;
    for (longint unsigned i = 0; i < t; i++) y = (y * y) % N_MOD;
    return y;
  endfunction

  task automatic check_v(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_d(input string tag, input logic [OPER_BITS-1:0] obs,
                         input logic [OPER_BITS-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed(lo64)=%0h expected(lo64)=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check_v({pfx, "_rdy"},     64'(o_rdy), 64'd1);
    check_v({pfx, "_sq_val"},  64'(o_sq_val), 64'd0);
    check_v({pfx, "_sq_red"},  64'(o_sq_reduce_only), 64'd0);
    check_v({pfx, "_val"},     64'(o_val), 64'd0);
    check_v({pfx, "_err"},     64'(o_err), 64'd0);
    check_v({pfx, "_iter"},    o_iter, 64'd0);
    check_d({pfx, "_dat"},     o_dat, '0);
    check_d({pfx, "_sq_dat"},  o_sq_dat, '0);
  endtask

  // Accept a job; returns #1 after the accepting edge (first ISSUE cycle).
  task automatic start_job(input string tag, input longint unsigned x,
                           input longint unsigned t, input bit push);
    int k;
    exp_t e;
    k = 0;
    while (o_rdy !== 1'b1 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check_v({tag, "_rdy_timeout"}, 64'(k >= 100), 64'd0);
    n_issue  = 0;
    n_red    = 0;
    last_red = 1'b0;
    i_dat    = OPER_BITS'(x);
    i_t      = t;
    i_val    = 1'b1;
    @(posedge clk); #1;
    i_val    = 1'b0;
    if (push) begin
      e.dat  = OPER_BITS'(exp_result(x, t));
      e.iter = t;
      sb.push_back(e);
    end
  endtask

  // Wait for o_val, check accept-to-valid latency and the scoreboard entry.
  task automatic wait_result(input string tag, input int exp_lat);
    int   lat;
    exp_t e;
    lat = 1;
    while (o_val !== 1'b1 && lat < 3000) begin
      @(posedge clk); #1; lat++;
    end
    check_v({tag, "_val_timeout"}, 64'(lat >= 3000), 64'd0);
    check_v({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (sb.size() == 0) begin
      check_v({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check_d({tag, "_dat"}, o_dat, e.dat);
      check_v({tag, "_iter"}, o_iter, e.iter);
    end
  endtask

  task automatic release_result(input string tag);
    i_rdy = 1'b1;
    @(posedge clk); #1;
    i_rdy = 1'b0;
    check_v({tag, "_idle_rdy"}, 64'(o_rdy), 64'd1);
    check_v({tag, "_idle_val"}, 64'(o_val), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int k;
    bit stable;
    logic [OPER_BITS-1:0] hold_exp;

    i_rst   = 1'b1;
    i_val   = 1'b0;
    i_dat   = '0;
    i_t     = '0;
    i_abort = 1'b0;
    i_rdy   = 1'b0;
    sq_en   = 1'b1;
    inj_val = 1'b0;
    inj_dat = '0;
    n_issue = 0;
    n_red   = 0;
    last_red = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    check_reset_state("reset");

    // T=3, x=5: four issues, only the last reduce-only, 5^8 mod N.
    start_job("t3", 64'd5, 64'd3, 1'b1);
    wait_result("t3", 4 * (L + 1) + 1);
    check_v("t3_issues", 64'(n_issue), 64'd4);
    check_v("t3_red_count", 64'(n_red), 64'd1);
    check_v("t3_last_red", 64'(last_red), 64'd1);
    release_result("t3");

    // T=0 with an unreduced operand: a single reduce-only pass.
    start_job("t0", N_MOD + 64'd2, 64'd0, 1'b1);
    wait_result("t0", (L + 1) + 1);
    check_v("t0_issues", 64'(n_issue), 64'd1);
    check_v("t0_red_count", 64'(n_red), 64'd1);
    release_result("t0");

    // T=10 with the result held 20 cycles by a stalled consumer.
    start_job("t10", 64'd7, 64'd10, 1'b1);
    wait_result("t10", 11 * (L + 1) + 1);
    hold_exp = OPER_BITS'(exp_result(64'd7, 64'd10));
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (!(o_val === 1'b1 && o_dat === hold_exp && o_rdy === 1'b0 && o_iter === 64'd10))
        stable = 1'b0;
    end
    check_v("t10_hold_stable", 64'(stable), 64'd1);
    release_result("t10");

    // Abort while waiting on iteration 4; the late return must be dropped.
    start_job("abort", 64'd3, 64'd10, 1'b0);
    k = 0;
    while (n_issue < 5 && k < 500) begin
      @(posedge clk); #1; k++;
    end
    check_v("abort_reach_timeout", 64'(k >= 500), 64'd0);
    check_v("abort_iter_before", o_iter, 64'd4);
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    check_v("abort_drain_rdy", 64'(o_rdy), 64'd0);
    k = 0;
    while (o_rdy !== 1'b1 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check_v("abort_idle_timeout", 64'(k >= 100), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check_v("abort_issues", 64'(n_issue), 64'd5);
    check_v("abort_no_val", 64'(o_val), 64'd0);
    check_v("abort_iter_after", o_iter, 64'd4);
    check_v("abort_err", 64'(o_err), 64'd0);
    check_d("abort_dat_kept", o_dat, hold_exp);

    start_job("after_abort", 64'd9, 64'd1, 1'b1);
    wait_result("after_abort", 2 * (L + 1) + 1);
    check_v("after_abort_issues", 64'(n_issue), 64'd2);
    release_result("after_abort");

    // Squarer never returns: error after exactly WDOG cycles in WAIT.
    sq_en = 1'b0;
    start_job("wdog", 64'd4, 64'd2, 1'b0);
    repeat (WDOG) @(posedge clk);
    #1;
    check_v("wdog_err_early", 64'(o_err), 64'd0);
    check_v("wdog_busy_early", 64'(o_rdy), 64'd0);
    @(posedge clk); #1;
    check_v("wdog_err_set", 64'(o_err), 64'd1);
    check_v("wdog_idle", 64'(o_rdy), 64'd1);
    check_v("wdog_issues", 64'(n_issue), 64'd1);
    sq_en = 1'b1;
    start_job("wdog_clear", 64'd6, 64'd1, 1'b1);
    check_v("wdog_err_cleared", 64'(o_err), 64'd0);
    wait_result("wdog_clear", 2 * (L + 1) + 1);
    release_result("wdog_clear");

    // Reset mid-loop followed by a stale squarer return.
    start_job("rst", 64'd2, 64'd5, 1'b0);
    k = 0;
    while (n_issue < 2 && k < 500) begin
      @(posedge clk); #1; k++;
    end
    check_v("rst_reach_timeout", 64'(k >= 500), 64'd0);
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst   = 1'b0;
    inj_val = 1'b1;
    inj_dat = OPER_BITS'(64'd777);
    n_issue = 0;
    check_reset_state("rst_mid");
    @(posedge clk); #1;
    inj_val = 1'b0;
    check_reset_state("rst_stale");
    repeat (12) @(posedge clk);
    #1;
    check_v("rst_no_issue", 64'(n_issue), 64'd0);
    check_reset_state("rst_quiet");

    check_v("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
